// File: rtl/alu_issue.sv
// Issue/sequencing stage in front of a combinational N-bit ALU: registers operands,
// captures the ALU result and flags, keeps an accumulator, and offers the result on valid/ready.
module alu_issue #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   in_f,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_acc,
    input  logic         acc_clr,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_f,
    input  logic [N-1:0] alu_y,
    input  logic         alu_eq,
    input  logic         alu_neq,
    input  logic         alu_lt,
    input  logic         alu_lte,
    input  logic         alu_gt,
    input  logic         alu_gte,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic [5:0]   out_flags,
    output logic         out_err,
    output logic [N-1:0] acc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] F_ILLEGAL = 3'b011;
    localparam logic [2:0] F_CMP     = 3'b111;

    state_t       state_q, state_d;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic [2:0]   op_f_q, op_f_d;
    logic [N-1:0] out_y_q, out_y_d;
    logic [5:0]   out_flags_q, out_flags_d;
    logic         out_err_q, out_err_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] acc_upd_s;

    // Next-state, operand capture, result capture and accumulator update.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_f_d      = op_f_q;
        out_y_d     = out_y_q;
        out_flags_d = out_flags_q;
        out_err_d   = out_err_q;
        acc_upd_s   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_a_d  = in_acc ? acc_q : in_a;
                    op_b_d  = in_b;
                    op_f_d  = in_f;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                out_err_d = (op_f_q == F_ILLEGAL);
                if (op_f_q == F_ILLEGAL) begin
                    out_y_d = {N{1'b0}};
                end else begin
                    out_y_d = alu_y;
                end
                if (op_f_q == F_CMP) begin
                    out_flags_d = {alu_gte, alu_gt, alu_lte, alu_lt, alu_neq, alu_eq};
                end else begin
                    out_flags_d = 6'b00_0000;
                end
                // Compare and the illegal code leave the accumulator alone.
                if ((op_f_q != F_CMP) && (op_f_q != F_ILLEGAL)) begin
                    acc_upd_s = alu_y;
                end else begin
                    acc_upd_s = acc_q;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (acc_clr) begin
            acc_d = {N{1'b0}};
        end else begin
            acc_d = acc_upd_s;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_a_q      <= {N{1'b0}};
            op_b_q      <= {N{1'b0}};
            op_f_q      <= 3'b000;
            out_y_q     <= {N{1'b0}};
            out_flags_q <= 6'b00_0000;
            out_err_q   <= 1'b0;
            acc_q       <= {N{1'b0}};
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_f_q      <= op_f_d;
            out_y_q     <= out_y_d;
            out_flags_q <= out_flags_d;
            out_err_q   <= out_err_d;
            acc_q       <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_f     = op_f_q;
    assign out_y     = out_y_q;
    assign out_flags = out_flags_q;
    assign out_err   = out_err_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU plus a transaction-level reference model.
module tb_alu_issue;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_acc, acc_clr;
    logic [2:0]   in_f, alu_f;
    logic [N-1:0] in_a, in_b, alu_a, alu_b, alu_y, out_y, acc;
    logic         alu_eq, alu_neq, alu_lt, alu_lte, alu_gt, alu_gte;
    logic         out_valid, out_ready, out_err;
    logic [5:0]   out_flags;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] model_acc;

    alu_issue #(.N(N)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_f(in_f), .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .alu_eq(alu_eq), .alu_neq(alu_neq), .alu_lt(alu_lt), .alu_lte(alu_lte),
        .alu_gt(alu_gt), .alu_gte(alu_gte), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_flags(out_flags), .out_err(out_err), .acc(acc)
    );

    always #5 clk = ~clk;

    // Reference ALU function; 011 returns a non-zero pattern so forced zeroing is visible.
    function automatic logic [N-1:0] ref_y(input logic [2:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b011:  return a ^ b;
            3'b100:  return a & ~b;
            3'b101:  return a | ~b;
            3'b110:  return a - b;
            default: return {N{1'b0}};
        endcase
    endfunction

    always_comb begin
        alu_y   = ref_y(alu_f, alu_a, alu_b);
        alu_eq  = (alu_a == alu_b);
        alu_neq = (alu_a != alu_b);
        alu_lt  = (alu_a <  alu_b);
        alu_lte = (alu_a <= alu_b);
        alu_gt  = (alu_a >  alu_b);
        alu_gte = (alu_a >= alu_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command: accept, EXEC, optional back-pressure in HOLD, handshake.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic use_acc, input int hold, input logic clr);
        logic [N-1:0] opa, ey;
        logic [5:0]   ef;
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_f = f; in_a = a; in_b = b; in_acc = use_acc; out_ready = 1'b1;
        opa = use_acc ? model_acc : a;
        ey  = (f == 3'b011) ? {N{1'b0}} : ref_y(f, opa, b);
        ef  = (f == 3'b111) ? {opa >= b, opa > b, opa <= b, opa < b, opa != b, opa == b} : 6'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_f = 3'($urandom); in_a = N'($urandom); in_b = N'($urandom); in_acc = 1'($urandom);
        check({tag, "_in_ready_exec"}, 32'(in_ready), 32'd0);
        check({tag, "_out_valid_exec"}, 32'(out_valid), 32'd0);
        acc_clr = clr;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        if (clr) model_acc = '0;
        else if (f != 3'b011 && f != 3'b111) model_acc = ey;
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_out_y"}, 32'(out_y), 32'(ey));
        check({tag, "_out_flags"}, 32'(out_flags), 32'(ef));
        check({tag, "_out_err"}, 32'(out_err), 32'(f == 3'b011));
        check({tag, "_acc"}, 32'(acc), 32'(model_acc));
        out_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_f = 3'($urandom); in_a = N'($urandom); in_b = N'($urandom);
            @(posedge clk); #1;
            check({tag, "_bp_out_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_bp_out_y"}, 32'(out_y), 32'(ey));
            check({tag, "_bp_out_flags"}, 32'(out_flags), 32'(ef));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_done_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_acc"}, 32'(acc), 32'(model_acc));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_f = 3'b000; in_a = '0; in_b = '0;
        in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1; model_acc = '0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_f", 32'(alu_f), 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed sequence with spec-literal expectations alongside the model.
        do_op("add", 3'b010, 8'h05, 8'h03, 1'b0, 0, 1'b0);
        check("add_acc_lit", 32'(acc), 32'h08);
        do_op("sub_wrap", 3'b110, 8'h00, 8'h01, 1'b0, 0, 1'b0);
        check("sub_acc_lit", 32'(acc), 32'hFF);
        do_op("cmp", 3'b111, 8'h03, 8'h07, 1'b0, 0, 1'b0);
        check("cmp_acc_lit", 32'(acc), 32'hFF);
        do_op("add_again", 3'b010, 8'h05, 8'h03, 1'b0, 0, 1'b0);
        do_op("accum_bp", 3'b010, 8'hAA, 8'h02, 1'b1, 4, 1'b0);
        check("accum_acc_lit", 32'(acc), 32'h0A);
        do_op("illegal", 3'b011, 8'h12, 8'h34, 1'b0, 0, 1'b0);
        check("illegal_acc_lit", 32'(acc), 32'h0A);
        do_op("clr_prio", 3'b010, 8'h01, 8'h01, 1'b0, 0, 1'b1);
        check("clr_acc_lit", 32'(acc), 32'h00);

        // Randomized commands, with occasional idle-cycle clears.
        for (int k = 0; k < 60; k++) begin
            do_op("rnd", 3'($urandom), N'($urandom), N'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 7) == 0) begin
                acc_clr = 1'b1;
                @(posedge clk); #1;
                acc_clr = 1'b0;
                model_acc = '0;
                check("idle_clr_acc", 32'(acc), 32'd0);
            end
        end

        // Reset while a result is held under back-pressure.
        do_op("pre_rst", 3'b010, 8'h10, 8'h20, 1'b0, 0, 1'b0);
        in_valid = 1'b1; in_f = 3'b010; in_a = 8'h21; in_b = 8'h01; in_acc = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("hold_before_rst", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_acc", 32'(acc), 32'd0);
        @(negedge clk); reset = 1'b0; out_ready = 1'b1;
        model_acc = '0;
        @(posedge clk); #1;
        check("after_rst_in_ready", 32'(in_ready), 32'd1);
        check("after_rst_out_valid", 32'(out_valid), 32'd0);
        check("after_rst_out_y", 32'(out_y), 32'd0);
        do_op("after_rst_op", 3'b010, 8'h07, 8'h01, 1'b1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Sequencing stage directly upstream of the N-bit combinational ALU. It accepts one operation per valid/ready handshake and registers the operands before driving the ALU's `a`/`b`/`f` inputs. It captures the ALU result and comparison flags into an output register, maintains an accumulator that later operations can use as operand A, and presents the result on a valid/ready output port.

## Interface
- `N`, default 8, datapath width; must match the ALU's `N`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: command valid.
- `in_ready` out 1: block can accept a command.
- `in_f` in 3: ALU function code.
- `in_a` in N: operand A; ignored when `in_acc`=1.
- `in_b` in N: operand B.
- `in_acc` in 1: use the accumulator as operand A.
- `acc_clr` in 1: synchronous accumulator clear.
- `alu_a`, `alu_b` out N: to the ALU `a`/`b` inputs.
- `alu_f` out 3: to the ALU `f` input.
- `alu_y` in N: from the ALU `y` output.
- `alu_eq`, `alu_neq`, `alu_lt`, `alu_lte`, `alu_gt`, `alu_gte` in 1 each: from the ALU flag outputs.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_y` out N: registered result.
- `out_flags` out 6: `{gte,gt,lte,lt,neq,eq}`.
- `out_err` out 1: the command used illegal code 3'b011.
- `acc` out N: current accumulator value.

## Operation
- FSM states: IDLE, EXEC, HOLD.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid&&in_ready`, capture into operand registers:
    - `op_a` = `in_acc` ? `acc` : `in_a` (accumulator value sampled this edge).
    - `op_b` = `in_b`.
    - `op_f` = `in_f`.
  - Go to EXEC.
- **EXEC**
  - `alu_a`/`alu_b`/`alu_f` are driven from the operand registers at all times; they hold their last values outside EXEC.
  - At the end of the cycle, capture the result into the output registers and go to HOLD:
    - `out_y` ← `alu_y`.
    - `out_flags` ← ALU flags when `op_f`=111, else 6'b0 (forced zero).
    - `out_err` ← (`op_f`==011).
    - When `op_f`=011, `out_y` ← 0.
- **HOLD**
  - `out_valid`=1.
  - `out_y`, `out_flags` and `out_err` are held stable until `out_valid&&out_ready`, then go to IDLE.
- **Accumulator update** (EXEC edge only): `acc` ← `alu_y` when `op_f` ∈ {000,001,010,100,101,110}. It is unchanged for 111 and 011.
- **`acc_clr`**
  - Sampled on any edge; `acc` ← 0.
  - It overrides an EXEC update on the same edge.
- **Arithmetic**
  - Modulo 2^N with no carry/borrow output; wrap-around is the required behaviour.
  - Comparisons are unsigned, as computed by the ALU.
- **Outputs are registered except:**
  - `in_ready` = (state==IDLE).
  - `out_valid` = (state==HOLD).
  - `alu_*` = operand registers.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - state=IDLE.
  - `op_a`, `op_b`, `acc`, `out_y` = 0.
  - `op_f`=3'b000; `out_flags`=0; `out_err`=0.
  - `out_valid`=0.
  - `in_ready`=1 after reset deassertion (IDLE).
- **Latency:** command accepted at edge T; result registered at edge T+1; `out_valid` high in the cycle after T+1.
- **Throughput:** at best one command per 3 cycles (IDLE, EXEC, HOLD with `out_ready` already high).
- **Back-pressure:** HOLD persists indefinitely while `out_ready`=0; `in_ready` stays 0 for that whole time.
- **`in_valid` outside IDLE:** ignored; the command is not captured, and the source must hold it per the valid/ready rule.
- **Reset mid-EXEC/HOLD:** the in-flight command is discarded, `out_valid` drops asynchronously, and `acc` is cleared.
- **`in_acc` after an update:** `in_acc`=1 accepted in the cycle after a HOLD→IDLE handshake sees the updated `acc`.

## Test plan
- **Add:** reset, then `in_a`=8'h05, `in_b`=8'h03, `in_f`=010.
  - Expect `out_valid` two cycles after acceptance.
  - Expect `out_y`=8'h08, `out_flags`=0, `out_err`=0, `acc`=8'h08.
- **Subtract with wrap:** `in_a`=8'h00, `in_b`=8'h01, `in_f`=110.
  - Expect `out_y`=8'hFF and `acc`=8'hFF.
- **Compare:** `in_a`=8'h03, `in_b`=8'h07, `in_f`=111.
  - Expect `out_y`=8'h00 and `out_flags`=6'b001110.
  - Expect `acc` unchanged.
- **Accumulate with back-pressure:** `acc`=8'h08, `in_acc`=1, `in_a`=8'hAA, `in_b`=8'h02, `in_f`=010, with `out_ready`=0 for 4 cycles.
  - During back-pressure, `out_y`=8'h0A held stable and `in_ready`=0.
  - After the handshake, `acc`=8'h0A.
- **Illegal code:** `in_f`=011 with `in_a`=8'h12, `in_b`=8'h34.
  - Expect `out_err`=1, `out_y`=8'h00, `out_flags`=0.
  - Expect `acc` unchanged.
- **Clear priority and reset mid-operation:**
  - `acc_clr`=1 on the EXEC edge of an add (`in_a`=1, `in_b`=1): expect `acc`=8'h00 while `out_y`=8'h02.
  - Assert `reset` during HOLD: expect `out_valid`=0 immediately, and state IDLE with `in_ready`=1 after deassertion.
